// File: rtl/light_sequencer.sv
// light_sequencer: free-running four-LED heartbeat pattern.
// A prescaler divides clk into steps of STEP_CYCLES cycles. On each step edge
// an 8-state pattern machine advances and the LED register is updated on that
// same edge, so the LEDs come straight from flops and never glitch.
`timescale 1ns/100ps
module light_sequencer #(
  parameter int STEP_CYCLES = 50,
  parameter int CNT_W       = 24
) (
  input  logic clk,
  input  logic rst,
  output logic led_1,
  output logic led_2,
  output logic led_3,
  output logic led_4
);

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_t;

  // Terminal prescaler count: the edge that sees this value is the step edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  // NOTE: declaration initialisers give the flops their reset values at
  // power-up, so the sequence runs correctly even if rst is never asserted.
  logic [CNT_W-1:0] cnt   = '0;
  state_t           state = S0;
  logic [3:0]       leds  = 4'b1000;   // {led_1, led_2, led_3, led_4}

  logic   step;
  state_t state_next;

  // LED pattern for a state; any unexpected encoding shows the S0 pattern.
  function automatic logic [3:0] decode(input state_t s);
    case (s)
      S0:      decode = 4'b1000;
      S1:      decode = 4'b0100;
      S2:      decode = 4'b0010;
      S3:      decode = 4'b0001;
      S4:      decode = 4'b0011;
      S5:      decode = 4'b0111;
      S6:      decode = 4'b1111;
      S7:      decode = 4'b0000;
      default: decode = 4'b1000;
    endcase
  endfunction

  // Successor state; an unexpected encoding is treated as S0 and moves on to S1.
  function automatic state_t advance(input state_t s);
    case (s)
      S0:      advance = S1;
      S1:      advance = S2;
      S2:      advance = S3;
      S3:      advance = S4;
      S4:      advance = S5;
      S5:      advance = S6;
      S6:      advance = S7;
      S7:      advance = S0;
      default: advance = S1;
    endcase
  endfunction

  // Step detection and next-state selection.
  always_comb begin
    step       = (cnt == CNT_LAST);
    state_next = advance(state);
  end

  // Prescaler, pattern state and LED register; reset discards all progress.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      state <= S0;
      leds  <= 4'b1000;
    end else if (step) begin
      cnt   <= '0;
      state <= state_next;
      leds  <= decode(state_next);
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign led_1 = leds[3];
  assign led_2 = leds[2];
  assign led_3 = leds[1];
  assign led_4 = leds[0];

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer: one instance with STEP_CYCLES=50 and one
// with STEP_CYCLES=1, both on a 2 ns clock whose first rising edge is at 1 ns.
`timescale 1ns/100ps
module tb_light_sequencer;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;   // never asserted before the power-up scenario
  logic rst_b = 1'b1;   // held until the STEP_CYCLES=1 scenario

  logic a1, a2, a3, a4;
  logic b1, b2, b3, b4;
  logic [3:0] leds_a, leds_b;

  int errors = 0;
  int checks = 0;

  always #1 clk = ~clk;

  assign leds_a = {a1, a2, a3, a4};
  assign leds_b = {b1, b2, b3, b4};

  light_sequencer #(.STEP_CYCLES(50), .CNT_W(24)) dut_a (
    .clk(clk), .rst(rst_a), .led_1(a1), .led_2(a2), .led_3(a3), .led_4(a4)
  );

  light_sequencer #(.STEP_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .led_1(b1), .led_2(b2), .led_3(b3), .led_4(b4)
  );

  // Reference pattern table, led_1..led_4, indexed by step number mod 8.
  function automatic logic [3:0] pat(input int k);
    case (k % 8)
      0: pat = 4'b1000;
      1: pat = 4'b0100;
      2: pat = 4'b0010;
      3: pat = 4'b0001;
      4: pat = 4'b0011;
      5: pat = 4'b0111;
      6: pat = 4'b1111;
      default: pat = 4'b0000;
    endcase
  endfunction

  task automatic test_power_up();
    #0.5;
    checks++;
    if (leds_a !== 4'b1000) begin
      errors++;
      $display("FAIL power_up_t0: got %b expected 1000", leds_a);
    end
    #99.5;  // t = 100 ns
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) #100;
      checks++;
      if (leds_a !== pat(k)) begin
        errors++;
        $display("FAIL power_up_%0dns: got %b expected %b", k * 100, leds_a, pat(k));
      end
    end
  endtask

  task automatic test_step_boundary();
    @(negedge clk) rst_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #0.5;
      checks++;
      if (leds_a !== ((n < 50) ? 4'b1000 : 4'b0100)) begin
        errors++;
        $display("FAIL boundary_edge%0d: got %b expected %b", n, leds_a,
                 (n < 50) ? 4'b1000 : 4'b0100);
      end
      if (n == 1) begin
        checks++;
        if (dut_a.cnt !== 24'd1) begin
          errors++;
          $display("FAIL boundary_cnt_first_edge: got %0d expected 1", dut_a.cnt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    // Continue from edge 50 (S1) to edge 160, ten edges into S3.
    for (int n = 51; n <= 160; n++) begin
      @(posedge clk); #0.5;
      if (n == 150) begin
        checks++;
        if (leds_a !== 4'b0001) begin
          errors++;
          $display("FAIL async_in_s3: got %b expected 0001", leds_a);
        end
      end
    end
    rst_a = 1'b1;  // between edges, no clock edge follows before the check
    #0.3;
    checks++;
    if (leds_a !== 4'b1000 || dut_a.cnt !== 24'd0) begin
      errors++;
      $display("FAIL async_immediate: got leds %b cnt %0d expected 1000 cnt 0",
               leds_a, dut_a.cnt);
    end
    @(negedge clk) rst_a = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #0.5;
      checks++;
      if (leds_a !== ((n < 50) ? 4'b1000 : 4'b0100)) begin
        errors++;
        $display("FAIL async_restart_edge%0d: got %b expected %b", n, leds_a,
                 (n < 50) ? 4'b1000 : 4'b0100);
      end
    end
  endtask

  task automatic test_reset_held();
    @(negedge clk) rst_a = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #0.5;
      checks++;
      if (leds_a !== 4'b1000 || dut_a.cnt !== 24'd0) begin
        errors++;
        $display("FAIL reset_held_cycle%0d: got leds %b cnt %0d expected 1000 cnt 0",
                 n, leds_a, dut_a.cnt);
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk) rst_a = 1'b0;
    for (int n = 1; n <= 16 * 50; n++) begin
      @(posedge clk); #0.5;
      checks++;
      if (leds_a !== pat(n / 50)) begin
        errors++;
        $display("FAIL wrap_edge%0d: got %b expected %b", n, leds_a, pat(n / 50));
      end
    end
  endtask

  task automatic test_step_one();
    checks++;
    if (leds_b !== 4'b1000) begin
      errors++;
      $display("FAIL step1_in_reset: got %b expected 1000", leds_b);
    end
    @(negedge clk) rst_b = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #0.5;
      checks++;
      if (leds_b !== pat(n) || dut_b.cnt !== 4'd0) begin
        errors++;
        $display("FAIL step1_edge%0d: got leds %b cnt %0d expected %b cnt 0",
                 n, leds_b, dut_b.cnt, pat(n));
      end
    end
  endtask

  initial begin
    test_power_up();
    test_step_boundary();
    test_async_reset();
    test_reset_held();
    test_wrap();
    test_step_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
